// File: rtl/checksum_checker_pkg.sv
// Shared widths and FSM state encoding for the checksum checker and its
// generator-side counterpart.
package checksum_checker_pkg;

  localparam int CRC_W  = 12;
  localparam int BYTE_W = 8;
  localparam int POLY_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    SHIFT,
    WAIT_CHK,
    DONE
  } state_t;

endpackage

// File: rtl/checksum_checker_bitstep.sv
// One bit of the CRC-12 LFSR with programmable low taps; G(x) = x^12 + p(x).
module crc12_bitstep
  import checksum_checker_pkg::*;
(
  input  logic [CRC_W-1:0]  crc_in,
  input  logic              in_bit,
  input  logic [POLY_W-1:0] poly,
  output logic [CRC_W-1:0]  crc_out
);

  logic fb;

  assign fb      = crc_in[CRC_W-1] ^ in_bit;
  assign crc_out = {crc_in[CRC_W-2:0], 1'b0} ^
                   (fb ? {{(CRC_W-POLY_W){1'b0}}, poly} : {CRC_W{1'b0}});

endmodule

// File: rtl/checksum_checker.sv
// Frame CRC-12 checker: bytes are shifted in serially (8 cycles each) and the
// final remainder is compared with a separately delivered checksum.
module checksum_checker
  import checksum_checker_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [POLY_W-1:0] polynomial,
  input  logic              in_data_vld,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_sof,
  input  logic              in_eof,
  output logic              in_data_rdy,
  input  logic              in_chk_vld,
  input  logic [CRC_W-1:0]  in_chk,
  output logic              in_chk_rdy,
  output logic              out_result_vld,
  output logic              out_pass,
  output logic [CRC_W-1:0]  out_crc,
  output logic              out_err
);

  state_t            state;
  logic [CRC_W-1:0]  crc;
  logic [CRC_W-1:0]  crc_next;
  logic [CRC_W-1:0]  crc_final;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] byte_q;
  logic [POLY_W-1:0] poly_q;
  logic              eof_q;
  logic              result_vld_q;
  logic              pass_q;
  logic [CRC_W-1:0]  crc_out_q;
  logic              err_q;
  logic              data_accept;
  logic              chk_accept;

  crc12_bitstep u_bitstep (
    .crc_in  (crc),
    .in_bit  (byte_q[BYTE_W-1]),
    .poly    (poly_q),
    .crc_out (crc_next)
  );

  // Outputs are masked by reset so they read as idle from the very first
  // reset cycle, before the synchronous clear has taken effect.
  assign in_data_rdy    = !reset && ((state == IDLE) || (state == COLLECT));
  assign in_chk_rdy     = !reset && (state == WAIT_CHK);
  assign out_result_vld = !reset && result_vld_q;
  assign out_pass       = !reset && pass_q;
  assign out_crc        = reset ? {CRC_W{1'b0}} : crc_out_q;
  assign out_err        = !reset && err_q;

  assign data_accept = in_data_vld && in_data_rdy;
  assign chk_accept  = in_chk_vld && in_chk_rdy;
  assign crc_final   = (poly_q == {POLY_W{1'b0}}) ? {CRC_W{1'b0}} : crc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      crc          <= '0;
      bit_cnt      <= '0;
      byte_q       <= '0;
      poly_q       <= '0;
      eof_q        <= 1'b0;
      result_vld_q <= 1'b0;
      pass_q       <= 1'b0;
      crc_out_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      result_vld_q <= 1'b0;
      err_q        <= 1'b0;
      case (state)
        IDLE, COLLECT: begin
          if (data_accept) begin
            if (in_sof) begin
              crc     <= '0;
              poly_q  <= polynomial;
              byte_q  <= in_data;
              eof_q   <= in_eof;
              bit_cnt <= '0;
              err_q   <= (state == COLLECT);
              state   <= SHIFT;
            end else if (state == IDLE) begin
              err_q <= 1'b1;
            end else begin
              byte_q  <= in_data;
              eof_q   <= in_eof;
              bit_cnt <= '0;
              state   <= SHIFT;
            end
          end
        end
        SHIFT: begin
          crc     <= crc_next;
          byte_q  <= {byte_q[BYTE_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state <= eof_q ? WAIT_CHK : COLLECT;
          end
        end
        WAIT_CHK: begin
          if (chk_accept) begin
            result_vld_q <= 1'b1;
            crc_out_q    <= crc_final;
            pass_q       <= (crc_final == in_chk);
            state        <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/checksum_checker.md
CHECKSUM_CHECKER -- requirements
Module: checksum_checker

Interface
REQ-001 SHALL have: clk  input  1  rising-edge clock.
REQ-002 SHALL have: reset  input  1  synchronous, active-high reset; clock clk.
REQ-003 SHALL have: polynomial  input  4  generator taps p[3:0]; G(x) = x^12 + p3·x^3 + p2·x^2 + p1·x + p0.
REQ-004 SHALL have: in_data_vld  input  1  payload byte valid.
REQ-005 SHALL have: in_data  input  8  payload byte, processed MSB first.
REQ-006 SHALL have: in_sof  input  1  qualifies the current byte as first of frame.
REQ-007 SHALL have: in_eof  input  1  qualifies the current byte as last of frame; sof and eof together form a 1-byte frame.
REQ-008 SHALL have: in_data_rdy  output  1  byte accepted when in_data_vld && in_data_rdy.
REQ-009 SHALL have: in_chk_vld  input  1  received 12-bit checksum valid.
REQ-010 SHALL have: in_chk  input  12  received checksum.
REQ-011 SHALL have: in_chk_rdy  output  1  checksum accepted when in_chk_vld && in_chk_rdy.
REQ-012 SHALL have: out_result_vld  output  1  1-cycle pulse, verdict valid.
REQ-013 SHALL have: out_pass  output  1  1 = computed checksum equals in_chk; held until next result.
REQ-014 SHALL have: out_crc  output  12  computed checksum; held until next result.
REQ-015 SHALL have: out_err  output  1  1-cycle pulse on a protocol violation.

Function
REQ-016 SHALL implement FSM states IDLE, COLLECT, SHIFT, WAIT_CHK, DONE.
REQ-017 In IDLE and COLLECT, in_data_rdy SHALL be 1; in SHIFT, WAIT_CHK and DONE, in_data_rdy SHALL be 0.
REQ-018 In IDLE, an accepted byte with in_sof=1 SHALL clear the 12-bit CRC register to 0, latch polynomial for the frame, latch the byte, and enter SHIFT.
REQ-019 In IDLE, an accepted byte with in_sof=0 SHALL be dropped, pulse out_err, and stay in IDLE.
REQ-020 In COLLECT, an accepted byte with in_sof=1 SHALL pulse out_err and restart the frame exactly as in REQ-018.
REQ-021 In COLLECT, an accepted byte with in_sof=0 SHALL be latched and SHALL enter SHIFT.
REQ-022 SHIFT SHALL last exactly 8 cycles and process one bit per cycle, MSB first.
REQ-023 Bit step: fb = crc[11] ^ bit; crc <= {crc[10:0],0} ^ (fb ? {8'h00, latched polynomial} : 0).
REQ-024 After 8 bits, SHIFT SHALL go to WAIT_CHK if the byte had eof, otherwise to COLLECT.
REQ-025 Byte throughput: a byte accepted in cycle N SHALL allow the next byte to be accepted no earlier than cycle N+9.
REQ-026 If the latched polynomial is 4'h0, the computed checksum SHALL be forced to 12'h000.
REQ-027 in_chk_rdy SHALL be 1 only in WAIT_CHK; in_chk_vld in any other state SHALL be ignored.
REQ-028 On checksum acceptance, the FSM SHALL enter DONE.
REQ-029 In DONE, for exactly one cycle, the block SHALL drive out_result_vld=1, out_crc=crc and out_pass=(crc==in_chk); the FSM SHALL then return to IDLE.
REQ-030 Latency: checksum accepted in cycle M SHALL produce out_result_vld in cycle M+1.
REQ-031 A change on polynomial mid-frame SHALL have no effect on the frame in progress.

Reset
REQ-032 While reset=1, the FSM SHALL enter IDLE and the CRC register, bit counter and latched byte/polynomial/eof SHALL clear to 0.
REQ-033 While reset=1, the outputs SHALL be: in_data_rdy=0, in_chk_rdy=0, out_result_vld=0, out_pass=0, out_crc=12'h000, out_err=0.
REQ-034 In the first cycle after reset deasserts, in_data_rdy SHALL be 1.
REQ-035 Reset asserted mid-frame SHALL abandon the frame with no result pulse.

Structure
REQ-036 A shared package SHALL hold the FSM state enum and the constants CRC_W=12, BYTE_W=8, POLY_W=4.
REQ-037 The bit-step update SHALL be a single sub-module, crc12_bitstep (crc_in, bit, poly -> crc_out), reusable by the generator side.

Verification
REQ-038 poly=4'h3, 1-byte frame 8'h80 (sof=eof=1), in_chk=12'h180 -> out_crc=12'h180, out_pass=1, result pulse 1 cycle after checksum acceptance.
REQ-039 poly=4'h3, frame {8'h80, 8'h00}, in_chk=12'h028 -> out_pass=1; repeat with in_chk=12'h029 -> out_crc=12'h028, out_pass=0.
REQ-040 poly=4'h0, frame {8'hFF}, in_chk=12'h000 -> out_crc=12'h000, out_pass=1.
REQ-041 Byte with sof=0 in IDLE -> out_err pulse, no state change; sof=1 byte in COLLECT -> out_err pulse and a fresh CRC (the REQ-038 frame still gives 12'h180).
REQ-042 in_data_vld held high continuously -> in_data_rdy low for exactly 8 cycles after each acceptance; in_chk_vld asserted before eof processing completes -> not accepted until WAIT_CHK.
REQ-043 Reset pulsed during SHIFT of a 2-byte frame -> no out_result_vld, in_data_rdy=1 on the first cycle after reset, and the next frame checks correctly.
